// File: rtl/cla_adder_pipe_pkg.sv
// Shared constants for the pipelined carry-lookahead adder/subtractor.
package cla_adder_pipe_pkg;
    localparam int   CLA_GROUP_W   = 4;
    localparam int   CLA_WIDTH_MIN = 4;
    localparam int   CLA_WIDTH_MAX = 64;
    localparam logic MODE_ADD      = 1'b0;
    localparam logic MODE_SUB      = 1'b1;

    function automatic logic cla_width_ok(input int w);
        return (w % CLA_GROUP_W == 0) && (w >= CLA_WIDTH_MIN) && (w <= CLA_WIDTH_MAX);
    endfunction
endpackage

// File: rtl/cla_group_lookahead.sv
// Flat sum-of-products lookahead: c[i+1] = G[i] | P[i]G[i-1] | ... | P[i:0]cin.
module cla_group_lookahead #(
    parameter int N = 4
) (
    input  logic [N-1:0] g,
    input  logic [N-1:0] p,
    input  logic         cin,
    output logic [N:0]   c
);
    assign c[0] = cin;

    for (genvar i = 0; i < N; i++) begin : g_carry
        logic [i+1:0] terms;
        for (genvar j = 0; j <= i; j++) begin : g_term
            if (j == i) begin : g_self
                assign terms[j] = g[j];
            end else begin : g_prop
                assign terms[j] = g[j] & (&p[i:j+1]);
            end
        end
        assign terms[i+1] = cin & (&p[i:0]);
        assign c[i+1]     = |terms;
    end
endmodule

// File: rtl/cla_adder_pipe.sv
// Two-stage carry-lookahead adder/subtractor with valid/ready flow control.
module cla_adder_pipe
    import cla_adder_pipe_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf,
    output logic             zero
);
    localparam int GROUPS = WIDTH / CLA_GROUP_W;

    if (!cla_width_ok(WIDTH)) begin : g_bad_width
        $error("cla_adder_pipe: WIDTH must be a multiple of 4 in [4,64]");
    end

    logic [2:1] vld_pipe;
    logic       s1_load, s2_load;

    assign s2_load   = !vld_pipe[2] || out_ready;
    assign s1_load   = !vld_pipe[1] || s2_load;
    assign in_ready  = s1_load;
    assign out_valid = vld_pipe[2];

    // Stage 1: operand conditioning and per-group generate/propagate
    logic [WIDTH-1:0]  b_eff, g_in, p_in;
    logic              c0_in;
    logic [GROUPS-1:0] gg_in, gp_in;

    assign b_eff = (sub == MODE_SUB) ? ~b : b;
    assign c0_in = (sub == MODE_SUB) ? 1'b1 : c_in;
    assign g_in  = a & b_eff;
    assign p_in  = a ^ b_eff;

    for (genvar k = 0; k < GROUPS; k++) begin : g_grp_gp
        logic [CLA_GROUP_W-1:0] gk, pk;
        assign gk       = g_in[k*CLA_GROUP_W +: CLA_GROUP_W];
        assign pk       = p_in[k*CLA_GROUP_W +: CLA_GROUP_W];
        assign gg_in[k] = gk[3] | (pk[3] & gk[2]) | (&pk[3:2] & gk[1]) | (&pk[3:1] & gk[0]);
        assign gp_in[k] = &pk;
    end

    logic [WIDTH-1:0]  s1_g, s1_p;
    logic [GROUPS-1:0] s1_gg, s1_gp;
    logic              s1_c0;

    // Stage 2: group carries first, then bit carries inside each group
    logic [GROUPS:0]                    grp_c;
    logic [GROUPS-1:0][CLA_GROUP_W:0]   bit_c;
    logic [GROUPS-1:0]                  unused_bit_cout;
    logic [WIDTH:0]                     carries;
    logic [WIDTH-1:0]                   sum_nx;

    cla_group_lookahead #(.N(GROUPS)) u_grp_la (
        .g   (s1_gg),
        .p   (s1_gp),
        .cin (s1_c0),
        .c   (grp_c)
    );

    for (genvar k = 0; k < GROUPS; k++) begin : g_bit_la
        cla_group_lookahead #(.N(CLA_GROUP_W)) u_bit_la (
            .g   (s1_g[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .p   (s1_p[k*CLA_GROUP_W +: CLA_GROUP_W]),
            .cin (grp_c[k]),
            .c   (bit_c[k])
        );
        assign carries[k*CLA_GROUP_W +: CLA_GROUP_W] = bit_c[k][CLA_GROUP_W-1:0];
        // group carry-out duplicates grp_c[k+1]; the top-level copy is the one used
        assign unused_bit_cout[k] = bit_c[k][CLA_GROUP_W];
    end

    assign carries[WIDTH] = grp_c[GROUPS];
    assign sum_nx         = s1_p ^ carries[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            s1_g     <= '0;
            s1_p     <= '0;
            s1_gg    <= '0;
            s1_gp    <= '0;
            s1_c0    <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            ovf      <= 1'b0;
            zero     <= 1'b0;
        end else begin
            if (s1_load) begin
                vld_pipe[1] <= in_valid;
                if (in_valid) begin
                    s1_g  <= g_in;
                    s1_p  <= p_in;
                    s1_gg <= gg_in;
                    s1_gp <= gp_in;
                    s1_c0 <= c0_in;
                end
            end
            if (s2_load) begin
                vld_pipe[2] <= vld_pipe[1];
                if (vld_pipe[1]) begin
                    sum   <= sum_nx;
                    c_out <= carries[WIDTH];
                    ovf   <= carries[WIDTH-1] ^ carries[WIDTH];
                    zero  <= ~|sum_nx;
                end
            end
        end
    end
endmodule
